// File: rtl/frame_buffer_pingpong.sv
// Two-buffer frame store between a camera writer and a display reader on one clock.
// The writer fills one buffer while the reader scans the other; buffers swap on a display SOF.
module frame_buffer_pingpong #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned H_RES  = 640,
  parameter int unsigned V_RES  = 480,
  parameter int unsigned ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_sof,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_sof,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              frame_ready,
  output logic              wr_buf,
  output logic              rd_buf,
  output logic [7:0]        drop_cnt
);

  localparam int unsigned FRAME_PIX = H_RES * V_RES;
  localparam int unsigned DEPTH     = 2 ** (ADDR_W + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_buf_q, wr_buf_d;
  logic              rd_buf_q, rd_buf_d;
  logic              pending_q, pending_d;
  logic              frame_ready_q, frame_ready_d;
  logic              wr_arm_q, wr_arm_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_gate_q, rd_gate_d;
  logic [DATA_W-1:0] ram_q;

  logic              wr_we;
  logic [ADDR_W-1:0] wr_loc;
  logic [ADDR_W-1:0] rd_loc;

  always_comb begin
    wr_buf_d      = wr_buf_q;
    rd_buf_d      = rd_buf_q;
    pending_d     = pending_q;
    frame_ready_d = frame_ready_q;
    wr_arm_d      = wr_arm_q;
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    drop_cnt_d    = drop_cnt_q;
    wr_we         = 1'b0;
    wr_loc        = wr_addr_q;

    // A SOF while a finished frame is still unclaimed starts a dropped frame.
    if (wr_sof) begin
      wr_loc = '0;
      if (pending_q) begin
        wr_arm_d = 1'b0;
        if (drop_cnt_q != 8'hFF) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end
      end else begin
        wr_arm_d  = 1'b1;
        wr_addr_d = '0;
        wr_we     = wr_valid;
      end
    end else if (wr_arm_q && wr_valid) begin
      wr_we = 1'b1;
    end

    if (wr_we) begin
      if (wr_loc == LAST_ADDR) begin
        wr_arm_d  = 1'b0;
        pending_d = 1'b1;
      end else begin
        wr_addr_d = wr_loc + 1'b1;
      end
    end

    // pending_q=1 implies the writer is disarmed, so this never races the set above.
    if (rd_sof && pending_q) begin
      rd_buf_d      = wr_buf_q;
      wr_buf_d      = ~wr_buf_q;
      pending_d     = 1'b0;
      frame_ready_d = 1'b1;
    end

    rd_loc = rd_sof ? '0 : rd_addr_q;
    if (rd_sof) begin
      rd_addr_d = '0;
    end
    if (rd_en) begin
      rd_addr_d = (rd_loc == LAST_ADDR) ? '0 : rd_loc + 1'b1;
    end

    rd_valid_d = rd_en;
    rd_gate_d  = rd_en ? frame_ready_d : rd_gate_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_buf_q      <= 1'b0;
      rd_buf_q      <= 1'b1;
      pending_q     <= 1'b0;
      frame_ready_q <= 1'b0;
      wr_arm_q      <= 1'b0;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      drop_cnt_q    <= 8'd0;
      rd_valid_q    <= 1'b0;
      rd_gate_q     <= 1'b0;
    end else begin
      wr_buf_q      <= wr_buf_d;
      rd_buf_q      <= rd_buf_d;
      pending_q     <= pending_d;
      frame_ready_q <= frame_ready_d;
      wr_arm_q      <= wr_arm_d;
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      drop_cnt_q    <= drop_cnt_d;
      rd_valid_q    <= rd_valid_d;
      rd_gate_q     <= rd_gate_d;
    end
  end

  // RAM: no reset so it maps onto block memory; read uses the post-swap buffer index.
  always_ff @(posedge clk) begin
    if (wr_we && !rst) begin
      mem[{wr_buf_q, wr_loc}] <= wr_data;
    end
    if (rd_en) begin
      ram_q <= mem[{rd_buf_d, rd_loc}];
    end
  end

  assign rd_data     = rd_gate_q ? ram_q : '0;
  assign rd_valid    = rd_valid_q;
  assign frame_ready = frame_ready_q;
  assign wr_buf      = wr_buf_q;
  assign rd_buf      = rd_buf_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
// Bench for frame_buffer_pingpong on a 4x2 frame: read data checked through a cycle-tagged queue.
module tb_frame_buffer_pingpong;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_sof = 1'b0;
  logic        wr_valid = 1'b0;
  logic [11:0] wr_data = '0;
  logic        rd_sof = 1'b0;
  logic        rd_en = 1'b0;
  logic [11:0] rd_data;
  logic        rd_valid;
  logic        frame_ready;
  logic        wr_buf;
  logic        rd_buf;
  logic [7:0]  drop_cnt;

  frame_buffer_pingpong #(
    .DATA_W(12), .H_RES(4), .V_RES(2), .ADDR_W(3)
  ) dut (
    .clk(clk), .rst(rst), .wr_sof(wr_sof), .wr_valid(wr_valid), .wr_data(wr_data),
    .rd_sof(rd_sof), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .frame_ready(frame_ready), .wr_buf(wr_buf), .rd_buf(rd_buf), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [11:0] data;
  } sb_t;

  typedef struct {
    logic [11:0] base;
    logic        exp_rd_buf;
    logic        exp_wr_buf;
  } vec_t;

  sb_t  sb[$];
  vec_t vecs[3];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Each expected read is tagged with the cycle its rd_valid must appear in.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      n_tests++;
      if (rd_valid !== 1'b1 || rd_data !== sb[0].data) begin
        n_fail++;
        $display("FAIL rd_data cyc=%0d: got valid=%b data=%h, want valid=1 data=%h",
                 cyc, rd_valid, rd_data, sb[0].data);
      end
      void'(sb.pop_front());
    end else if (rd_valid !== 1'b0) begin
      n_tests++;
      n_fail++;
      $display("FAIL rd_valid cyc=%0d: got %b, want 0", cyc, rd_valid);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic push_rd(input logic [11:0] data);
    sb_t e;
    e.cyc  = cyc + 1;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic write_frame(input logic [11:0] base, input int n, input bit with_sof);
    for (int i = 0; i < n; i++) begin
      wr_sof   = with_sof && (i == 0);
      wr_valid = 1'b1;
      wr_data  = base + 12'(i);
      step();
    end
    wr_sof   = 1'b0;
    wr_valid = 1'b0;
  endtask

  task automatic read_seq(input int n, input logic [11:0] base, input bit zero);
    for (int i = 0; i < n; i++) begin
      rd_sof = (i == 0);
      rd_en  = 1'b1;
      push_rd(zero ? 12'h000 : base + 12'(i % 8));
      step();
    end
    rd_sof = 1'b0;
    rd_en  = 1'b0;
    step();
    step();
  endtask

  task automatic chk_bufs(input string tag, input logic erd, input logic ewr, input logic efr);
    chk({tag, " rd_buf"}, 32'(rd_buf), 32'(erd));
    chk({tag, " wr_buf"}, 32'(wr_buf), 32'(ewr));
    chk({tag, " frame_ready"}, 32'(frame_ready), 32'(efr));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{base: 12'h001, exp_rd_buf: 1'b0, exp_wr_buf: 1'b1};
    vecs[1] = '{base: 12'h0B0, exp_rd_buf: 1'b1, exp_wr_buf: 1'b0};
    vecs[2] = '{base: 12'h0C0, exp_rd_buf: 1'b0, exp_wr_buf: 1'b1};

    // Reset values, checked while rst is still asserted.
    rst = 1'b1;
    step(); step(); step();
    chk_bufs("reset", 1'b1, 1'b0, 1'b0);
    chk("reset drop_cnt", 32'(drop_cnt), 32'd0);
    chk("reset rd_data", 32'(rd_data), 32'd0);
    rst = 1'b0;
    step();

    // Reads before any frame: valid follows rd_en, data forced to 0.
    read_seq(8, 12'h000, 1'b1);
    chk_bufs("no frame", 1'b1, 1'b0, 1'b0);

    // Ping-pong: each complete frame swaps in at the next rd_sof.
    for (int v = 0; v < 3; v++) begin
      write_frame(vecs[v].base, 8, 1'b1);
      step();
      read_seq(8, vecs[v].base, 1'b0);
      chk_bufs($sformatf("vec%0d", v), vecs[v].exp_rd_buf, vecs[v].exp_wr_buf, 1'b1);
      chk($sformatf("vec%0d drop_cnt", v), 32'(drop_cnt), 32'd0);
    end

    // Frame A pending, next camera frame is dropped and never written.
    write_frame(12'h100, 8, 1'b1);
    step();
    write_frame(12'h200, 8, 1'b1);
    chk("drop once", 32'(drop_cnt), 32'd1);
    read_seq(8, 12'h100, 1'b0);
    chk_bufs("after drop", 1'b1, 1'b0, 1'b1);

    // Abandoned partial frame: restart on the same buffer, only one pending.
    write_frame(12'h300, 5, 1'b1);
    write_frame(12'h0A0, 8, 1'b1);
    chk("abandon no drop", 32'(drop_cnt), 32'd1);
    read_seq(8, 12'h0A0, 1'b0);
    chk_bufs("abandon swap", 1'b0, 1'b1, 1'b1);
    read_seq(8, 12'h0A0, 1'b0);
    chk_bufs("no second swap", 1'b0, 1'b1, 1'b1);

    // Completion coincides with rd_sof: old frame stays on display.
    write_frame(12'h400, 7, 1'b1);
    wr_valid = 1'b1;
    wr_data  = 12'h407;
    rd_sof   = 1'b1;
    rd_en    = 1'b1;
    push_rd(12'h0A0);
    step();
    wr_valid = 1'b0;
    rd_sof   = 1'b0;
    for (int i = 1; i < 8; i++) begin
      push_rd(12'h0A0 + 12'(i));
      step();
    end
    rd_en = 1'b0;
    step(); step();
    chk_bufs("coincident", 1'b0, 1'b1, 1'b1);
    read_seq(8, 12'h400, 1'b0);
    chk_bufs("late swap", 1'b1, 1'b0, 1'b1);

    // Read address wraps after the last pixel.
    read_seq(10, 12'h400, 1'b0);
    chk_bufs("wrap", 1'b1, 1'b0, 1'b1);

    // Reset mid-frame; unframed pixels afterwards must be ignored.
    write_frame(12'h500, 4, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_bufs("mid rst", 1'b1, 1'b0, 1'b0);
    chk("mid rst drop_cnt", 32'(drop_cnt), 32'd0);
    write_frame(12'h600, 8, 1'b0);
    write_frame(12'h700, 8, 1'b1);
    read_seq(8, 12'h700, 1'b0);
    chk_bufs("post rst", 1'b0, 1'b1, 1'b1);

    // Drop counter saturation.
    write_frame(12'h800, 8, 1'b1);
    step();
    wr_sof = 1'b1;
    step();
    chk("drop 1", 32'(drop_cnt), 32'd1);
    for (int i = 1; i < 255; i++) step();
    chk("drop 255", 32'(drop_cnt), 32'd255);
    for (int i = 255; i < 300; i++) step();
    wr_sof = 1'b0;
    step();
    chk("drop sat", 32'(drop_cnt), 32'd255);

    step(); step();
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
